// File: rtl/register_dump_controller.sv
// Streams the register-file snapshot out over the UART TX byte
// interface: optional header byte, then each register MSB first.
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous, active-low reset
//   start        dump request, only sampled while idle
//   reg_data_in  snapshot word selected externally by reg_index
//   tx_done      one-cycle pulse: UART finished the current byte
//   reg_index    register currently being dumped
//   tx_data      byte presented to the UART while tx_start is high
//   tx_start     one-cycle pulse: UART loads tx_data
//   busy         high for the whole dump
//   done         one-cycle pulse after the last byte completes
module register_dump_controller #(
  parameter int unsigned NUM_REGS    = 32,
  parameter bit          SEND_HEADER = 1'b1,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] reg_data_in,
  input  logic        tx_done,
  output logic [4:0]  reg_index,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WAIT_HDR,
    LOAD,
    SEND,
    WAIT_BYTE,
    FINISH
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  reg_index_q, reg_index_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      reg_index_q <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      word_q      <= '0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      reg_index_q <= reg_index_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  // Outputs are registered, so each tx_start/done pulse is
  // raised on the edge that enters the state which owns it.
  always_comb begin
    state_d     = state_q;
    reg_index_d = reg_index_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          reg_index_d = '0;
          byte_cnt_d  = '0;
          busy_d      = 1'b1;
          if (SEND_HEADER) begin
            state_d    = HEADER;
            tx_start_d = 1'b1;
            tx_data_d  = HEADER_BYTE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      HEADER: begin
        state_d = WAIT_HDR;
      end

      WAIT_HDR: begin
        if (tx_done) begin
          state_d = LOAD;
        end
      end

      // Word is captured here so later register-file writes
      // cannot tear the four bytes of this register.
      LOAD: begin
        word_d     = reg_data_in;
        byte_cnt_d = '0;
        state_d    = SEND;
        tx_start_d = 1'b1;
        tx_data_d  = reg_data_in[31:24];
      end

      SEND: begin
        state_d = WAIT_BYTE;
      end

      WAIT_BYTE: begin
        if (tx_done) begin
          word_d = {word_q[23:0], 8'h00};
          if (byte_cnt_q < 2'd3) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = SEND;
            tx_start_d = 1'b1;
            tx_data_d  = word_q[23:16];
          end else if (reg_index_q == LAST_IDX) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            reg_index_d = reg_index_q + 5'd1;
            state_d     = LOAD;
          end
        end
      end

      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign reg_index = reg_index_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_register_dump_controller.sv
// Directed bench for register_dump_controller: full dump,
// headerless two-register dump, latching, noise, reset, stall.
module tb_register_dump_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        tx_done = 1'b0;
  logic [31:0] reg_data_in;
  logic [4:0]  reg_index;
  logic [7:0]  tx_data;
  logic        tx_start, busy, done;

  logic        start2 = 1'b0;
  logic        tx_done2 = 1'b0;
  logic [31:0] reg_data_in2;
  logic [4:0]  reg_index2;
  logic [7:0]  tx_data2;
  logic        tx_start2, busy2, done2;

  logic [31:0] rf  [32];
  logic [31:0] rf2 [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic [7:0] q2[$];
  logic [4:0] idx2[$];
  int done_cnt = 0;
  int viol = 0;
  bit prev_start = 0;
  bit hold = 0;
  bit stray_en = 0;
  int cnt = 0;
  bit pend = 0;
  int cnt2 = 0;
  bit pend2 = 0;
  int done2_cnt = 0;

  always #5 clock = ~clock;

  assign reg_data_in  = rf[reg_index];
  assign reg_data_in2 = rf2[reg_index2[0]];

  register_dump_controller dut (
    .clock(clock), .reset(reset), .start(start),
    .reg_data_in(reg_data_in), .tx_done(tx_done),
    .reg_index(reg_index), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .done(done)
  );

  register_dump_controller #(
    .NUM_REGS(2), .SEND_HEADER(1'b0), .HEADER_BYTE(8'hA5)
  ) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .reg_data_in(reg_data_in2), .tx_done(tx_done2),
    .reg_index(reg_index2), .tx_data(tx_data2),
    .tx_start(tx_start2), .busy(busy2), .done(done2)
  );

  // UART model: tx_done 10 cycles after each tx_start;
  // optional stray tx_done aligned with tx_start.
  always @(negedge clock) begin
    tx_done = 1'b0;
    if (!reset) begin
      pend = 0;
    end else begin
      if (pend && !hold) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          tx_done = 1'b1;
          pend = 0;
        end
      end
      if (tx_start) begin
        pend = 1;
        cnt = 10;
        if (stray_en) tx_done = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    tx_done2 = 1'b0;
    if (!reset) begin
      pend2 = 0;
    end else begin
      if (pend2) begin
        cnt2 = cnt2 - 1;
        if (cnt2 == 0) begin
          tx_done2 = 1'b1;
          pend2 = 0;
        end
      end
      if (tx_start2) begin
        pend2 = 1;
        cnt2 = 3;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      prev_start = 0;
    end else begin
      if (tx_start) begin
        q.push_back(tx_data);
        if (prev_start) viol++;
      end
      prev_start = tx_start;
      if (done) done_cnt++;
      if (tx_start2) begin
        q2.push_back(tx_data2);
        idx2.push_back(reg_index2);
      end
      if (done2) done2_cnt++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(8'(rf[r] >> (8 * b)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 3000) begin
      tick();
      t++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done=%b want 1", name, done);
    end
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if ({reg_index, tx_data, tx_start, busy, done} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {reg_index, tx_data, tx_start, busy, done});
    end
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b tx_start=%b want 0 0",
               busy, tx_start);
    end
  endtask

  task automatic test_full_dump();
    int bad, base;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'd10; rf[3] = 32'd15; rf[5] = 32'd15;
    rf[6] = 32'd12; rf[15] = 32'd20;
    build_exp();
    q.delete();
    viol = 0;
    base = done_cnt;
    pulse_start();
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_byte: start=%b data=%h busy=%b want 1 a5 1",
               tx_start, tx_data, busy);
    end
    wait_done("full");
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_finish: got %b want 1", busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_falls: busy=%b done=%b want 0 0", busy, done);
    end
    tick();
    tick();
    n_checks++;
    if (q.size() !== 129) begin
      n_fail++;
      $display("FAIL full_count: got %0d want 129", q.size());
    end
    bad = 0;
    for (int i = 0; i < q.size() && i < 129; i++)
      if (q[i] !== exp_q[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_stream: %0d bytes differ want 0", bad);
    end
    n_checks++;
    if (q.size() >= 65 &&
        {q[8], q[16], q[64]} !== {8'h0A, 8'h0F, 8'h14}) begin
      n_fail++;
      $display("FAIL full_spot: got %h %h %h want 0a 0f 14",
               q[8], q[16], q[64]);
    end
    n_checks++;
    if (done_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL full_done_once: got %0d want 1", done_cnt - base);
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL back_to_back_start: got %0d want 0", viol);
    end
    n_checks++;
    if (reg_index !== 5'd31) begin
      n_fail++;
      $display("FAIL index_hold: got %0d want 31", reg_index);
    end
  endtask

  task automatic test_latched_word();
    int t;
    q.delete();
    pulse_start();
    t = 0;
    while (q.size() < 6 && t < 2000) begin
      tick();
      t++;
    end
    rf[1] = 32'hFFFF_FFFF;
    wait_done("latch");
    tick();
    rf[1] = 32'd10;
    n_checks++;
    if (q.size() < 9 ||
        {q[5], q[6], q[7], q[8]} !== 32'h0000_000A) begin
      n_fail++;
      $display("FAIL latched_word: got %h%h%h%h want 0000000a",
               q[5], q[6], q[7], q[8]);
    end
  endtask

  task automatic test_start_and_stray();
    int t, bad, base;
    q.delete();
    base = done_cnt;
    stray_en = 1;
    pulse_start();
    t = 0;
    while (!done && t < 3000) begin
      if (t % 50 == 25) start = 1'b1;
      tick();
      start = 1'b0;
      t++;
    end
    stray_en = 0;
    tick();
    tick();
    tick();
    n_checks++;
    if (q.size() !== 129 || done_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL stray_count: bytes=%0d dones=%0d want 129 1",
               q.size(), done_cnt - base);
    end
    bad = 0;
    for (int i = 0; i < q.size() && i < 129; i++)
      if (q[i] !== exp_q[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stray_stream: %0d bytes differ want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int t, bad;
    q.delete();
    pulse_start();
    t = 0;
    while (q.size() < 19 && t < 2000) begin
      tick();
      t++;
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({reg_index, tx_data, tx_start, busy, done} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h want 0",
               {reg_index, tx_data, tx_start, busy, done});
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    q.delete();
    pulse_start();
    n_checks++;
    if (tx_data !== 8'hA5 || reg_index !== 5'd0) begin
      n_fail++;
      $display("FAIL restart_header: data=%h idx=%0d want a5 0",
               tx_data, reg_index);
    end
    wait_done("restart");
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < q.size() && i < 129; i++)
      if (q[i] !== exp_q[i]) bad++;
    n_checks++;
    if (q.size() !== 129 || bad != 0) begin
      n_fail++;
      $display("FAIL restart_stream: bytes=%0d bad=%0d want 129 0",
               q.size(), bad);
    end
  endtask

  task automatic test_holdoff();
    int t, n, starts, idle;
    q.delete();
    pulse_start();
    t = 0;
    while (q.size() < 3 && t < 2000) begin
      tick();
      t++;
    end
    hold = 1;
    n = q.size();
    starts = 0;
    idle = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tx_start !== 1'b0) starts++;
      if (busy !== 1'b1) idle++;
    end
    n_checks++;
    if (starts != 0 || q.size() != n) begin
      n_fail++;
      $display("FAIL hold_no_send: starts=%0d bytes=%0d want 0 %0d",
               starts, q.size(), n);
    end
    n_checks++;
    if (idle != 0) begin
      n_fail++;
      $display("FAIL hold_busy: low_cycles=%0d want 0", idle);
    end
    hold = 0;
    wait_done("hold");
    tick();
    tick();
    n_checks++;
    if (q.size() !== 129) begin
      n_fail++;
      $display("FAIL hold_count: got %0d want 129", q.size());
    end
  endtask

  task automatic test_no_header();
    logic [63:0] got;
    logic [7:0]  ix;
    int t;
    rf2[0] = 32'h1122_3344;
    rf2[1] = 32'hAABB_CCDD;
    q2.delete();
    idx2.delete();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    t = 0;
    while (!done2 && t < 500) begin
      tick();
      t++;
    end
    tick();
    tick();
    n_checks++;
    if (q2.size() !== 8 || done2_cnt !== 1) begin
      n_fail++;
      $display("FAIL nohdr_count: bytes=%0d dones=%0d want 8 1",
               q2.size(), done2_cnt);
    end
    got = '0;
    ix = '0;
    for (int i = 0; i < q2.size() && i < 8; i++) begin
      got = {got[55:0], q2[i]};
      ix  = {ix[6:0], idx2[i][0]};
    end
    n_checks++;
    if (got !== 64'h1122_3344_AABB_CCDD) begin
      n_fail++;
      $display("FAIL nohdr_stream: got %h want 11223344aabbccdd", got);
    end
    n_checks++;
    if (ix !== 8'b0000_1111) begin
      n_fail++;
      $display("FAIL nohdr_index: got %b want 00001111", ix);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf2[0] = 32'h0;
    rf2[1] = 32'h0;
    test_reset();
    test_full_dump();
    test_latched_word();
    test_start_and_stray();
    test_reset_mid();
    test_holdoff();
    test_no_header();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
